nrf_spi_master: RTL

NRF_SPI_MASTER -- requirements
Module: nrf_spi_master

---
 rtl/nrf_spi_master.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/nrf_spi_master.sv
// Avalon-MM SPI master for an nRF transceiver: mode 0, MSB first, one byte per TXDATA write.
// Chip select is purely software-driven through the CONTROL register.
module nrf_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        miso,
  output logic        mosi,
  output logic        sclk,
  output logic        csn,
  output logic [1:0]  state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  logic        control_q, control_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        miso_meta_q, miso_sync_q;
  logic [31:0] readdata_q, readdata_d;

  logic bus_wr, bus_rd, tx_wr, rx_set;
  logic unused_wdata;

  assign unused_wdata = &{1'b0, writedata[31:8]};

  assign bus_wr = chipselect & ~write_n;
  assign bus_rd = chipselect & write_n;
  assign tx_wr  = bus_wr && (address == 2'd0);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_byte_d  = rx_byte_q;
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    control_d  = control_q;
    rx_set     = 1'b0;
    readdata_d = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (tx_wr) begin
          shift_d = writedata[7:0];
          mosi_d  = writedata[7];
          div_d   = 8'd0;
          bit_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = 8'd0;
          sclk_d  = 1'b1;
          shift_d = {shift_q[6:0], miso_sync_q};
          state_d = S_HIGH;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d  = 8'd0;
          sclk_d = 1'b0;
          // shift_q has already moved the next outgoing bit into bit 7
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            mosi_d  = shift_q[7];
            state_d = S_LOW;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_DONE: begin
        rx_byte_d = shift_q;
        rx_set    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Set beats clear for both sticky status flags.
    rx_valid_d = rx_valid_q;
    if (bus_rd && (address == 2'd1)) rx_valid_d = 1'b0;
    if (rx_set) rx_valid_d = 1'b1;

    overrun_d = overrun_q;
    if (bus_wr && (address == 2'd2) && writedata[2]) overrun_d = 1'b0;
    if (tx_wr && busy_q) overrun_d = 1'b1;

    if (bus_wr && (address == 2'd3)) control_d = writedata[0];

    case (address)
      2'd1:    readdata_d = {24'd0, rx_byte_q};
      2'd2:    readdata_d = {29'd0, overrun_q, rx_valid_q, busy_q};
      2'd3:    readdata_d = {31'd0, control_q};
      default: readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      div_q       <= 8'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      rx_byte_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      control_q   <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
      readdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      control_q   <= control_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      miso_meta_q <= miso;
      miso_sync_q <= miso_meta_q;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata    = readdata_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign csn         = control_q;
  assign state_dbg_o = state_q;

endmodule
